display_scan: RTL

Parametrised successor to the 4-digit 14/15-segment display driver. Time-multiplexes DIGITS active-low 15-segment patterns onto one shared segment bus, with a programmable per-digit scan rate, an anti-ghosting blank interval, frame-coherent pattern snapshots and per-digit blinking. It also tracks a `remain` count and raises stretched entry/exit indications when the count falls or rises. It sits between the parking/counter logic, which supplies the patterns and count, and the board's digit/segment pins.

---
 rtl/display_scan_if.sv | 30 +++
 rtl/display_scan.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/display_scan_if.sv
`default_nettype none
// ============================================================================
// Interface : display_scan_if
// Purpose   : pattern/count inputs and digit/segment/indication outputs
// Revision  : 1.0
// ============================================================================
interface display_scan_if #(
    parameter int DIGITS  = 4,
    parameter int COUNT_W = 4
);
    logic [DIGITS*15-1:0] seg_in;
    logic [DIGITS-1:0]    blink;
    logic [COUNT_W-1:0]   remain;
    logic [DIGITS-1:0]    dig;
    logic [14:0]          seg;
    logic                 entry;
    logic                 exit;
    logic                 frame_start;

    modport master (
        output seg_in, blink, remain,
        input  dig, seg, entry, exit, frame_start
    );

    modport slave (
        input  seg_in, blink, remain,
        output dig, seg, entry, exit, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/display_scan.sv
`default_nettype none
// ============================================================================
// Module   : display_scan
// Purpose  : multiplexed 15-segment scan driver with entry/exit hold outputs
// Revision : 1.0
// ============================================================================
module display_scan #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 1024,
    parameter int BLANK        = 16,
    parameter int BLINK_FRAMES = 64,
    parameter int COUNT_W      = 4,
    parameter int RESET_COUNT  = 12,
    parameter int HOLD_CYCLES  = 50_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    display_scan_if.slave bus
);
    localparam int C_PRE_W  = $clog2(SCAN_DIV);
    localparam int C_IDX_W  = $clog2(DIGITS);
    localparam int C_FC_W   = $clog2(BLINK_FRAMES + 1);
    localparam int C_HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int C_SEG_W  = DIGITS * 15;

    localparam logic [C_PRE_W-1:0]  C_PRE_MAX     = C_PRE_W'(SCAN_DIV - 1);
    localparam logic [C_PRE_W-1:0]  C_PRE_ONE     = C_PRE_W'(1);
    localparam logic [C_PRE_W-1:0]  C_BLANK       = C_PRE_W'(BLANK);
    localparam logic [C_IDX_W-1:0]  C_IDX_MAX     = C_IDX_W'(DIGITS - 1);
    localparam logic [C_IDX_W-1:0]  C_IDX_ONE     = C_IDX_W'(1);
    localparam logic [C_FC_W-1:0]   C_FC_MAX      = C_FC_W'(BLINK_FRAMES);
    localparam logic [C_FC_W-1:0]   C_FC_ONE      = C_FC_W'(1);
    localparam logic [C_HOLD_W-1:0] C_HOLD        = C_HOLD_W'(HOLD_CYCLES);
    localparam logic [C_HOLD_W-1:0] C_HOLD_ONE    = C_HOLD_W'(1);
    localparam logic [DIGITS-1:0]   C_DIG_ONE     = DIGITS'(1);
    localparam logic [COUNT_W-1:0]  C_RESET_COUNT = COUNT_W'(RESET_COUNT);

    logic [C_PRE_W-1:0]  pre_q, pre_d;
    logic [C_IDX_W-1:0]  idx_q, idx_d;
    logic                started_q, started_d;
    logic [C_SEG_W-1:0]  shadow_seg_q, shadow_seg_d;
    logic [DIGITS-1:0]   shadow_blink_q, shadow_blink_d;
    logic [C_FC_W-1:0]   fc_q, fc_d;
    logic                blink_phase_q, blink_phase_d;
    logic                frame_start_q, frame_start_d;
    logic [DIGITS-1:0]   dig_q, dig_d;
    logic [14:0]         seg_q, seg_d;
    logic [COUNT_W-1:0]  prev_q, prev_d;
    logic [C_HOLD_W-1:0] entry_cnt_q, entry_cnt_d;
    logic [C_HOLD_W-1:0] exit_cnt_q, exit_cnt_d;
    logic                entry_q, entry_d;
    logic                exit_q, exit_d;

    logic w_pre_wrap;
    logic w_capture;

    always_comb begin
        w_pre_wrap = (pre_q == C_PRE_MAX);
        // The very first edge out of reset loads the shadows so frame 0 has real patterns.
        w_capture  = !started_q || (w_pre_wrap && (idx_q == C_IDX_MAX));
        started_d  = 1'b1;

        pre_d = w_pre_wrap ? '0 : pre_q + C_PRE_ONE;
        idx_d = idx_q;
        if (w_pre_wrap) begin
            idx_d = (idx_q == C_IDX_MAX) ? '0 : idx_q + C_IDX_ONE;
        end

        shadow_seg_d   = shadow_seg_q;
        shadow_blink_d = shadow_blink_q;
        fc_d           = fc_q;
        blink_phase_d  = blink_phase_q;
        frame_start_d  = w_capture;
        if (w_capture) begin
            shadow_seg_d   = bus.seg_in;
            shadow_blink_d = bus.blink;
            // fc counts captures in the current phase; the phase flips on the capture after BLINK_FRAMES of them.
            if (fc_q == C_FC_MAX) begin
                fc_d          = C_FC_ONE;
                blink_phase_d = !blink_phase_q;
            end else begin
                fc_d = fc_q + C_FC_ONE;
            end
        end

        dig_d = '1;
        seg_d = '1;
        if (pre_q >= C_BLANK) begin
            dig_d = ~(C_DIG_ONE << idx_q);
            if (!(blink_phase_q && shadow_blink_q[idx_q])) begin
                seg_d = shadow_seg_q[15*int'(idx_q) +: 15];
            end
        end

        prev_d      = bus.remain;
        entry_cnt_d = (entry_cnt_q != '0) ? entry_cnt_q - C_HOLD_ONE : entry_cnt_q;
        exit_cnt_d  = (exit_cnt_q  != '0) ? exit_cnt_q  - C_HOLD_ONE : exit_cnt_q;
        if (bus.remain < prev_q) begin
            entry_cnt_d = C_HOLD;
            exit_cnt_d  = '0;
        end else if (bus.remain > prev_q) begin
            exit_cnt_d  = C_HOLD;
            entry_cnt_d = '0;
        end
        entry_d = (entry_cnt_d != '0);
        exit_d  = (exit_cnt_d  != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q          <= '0;
            idx_q          <= '0;
            started_q      <= 1'b0;
            shadow_seg_q   <= '1;
            shadow_blink_q <= '0;
            fc_q           <= '0;
            blink_phase_q  <= 1'b0;
            frame_start_q  <= 1'b0;
            dig_q          <= '1;
            seg_q          <= '1;
            prev_q         <= C_RESET_COUNT;
            entry_cnt_q    <= '0;
            exit_cnt_q     <= '0;
            entry_q        <= 1'b0;
            exit_q         <= 1'b0;
        end else begin
            pre_q          <= pre_d;
            idx_q          <= idx_d;
            started_q      <= started_d;
            shadow_seg_q   <= shadow_seg_d;
            shadow_blink_q <= shadow_blink_d;
            fc_q           <= fc_d;
            blink_phase_q  <= blink_phase_d;
            frame_start_q  <= frame_start_d;
            dig_q          <= dig_d;
            seg_q          <= seg_d;
            prev_q         <= prev_d;
            entry_cnt_q    <= entry_cnt_d;
            exit_cnt_q     <= exit_cnt_d;
            entry_q        <= entry_d;
            exit_q         <= exit_d;
        end
    end

    assign bus.dig         = dig_q;
    assign bus.seg         = seg_q;
    assign bus.entry       = entry_q;
    assign bus.exit        = exit_q;
    assign bus.frame_start = frame_start_q;
endmodule
`default_nettype wire
